// File: rtl/e1b_code_loader.sv
// Unpacks 16-bit host words into 12-bit E1B code entries and drives the code memory write port.
// Latency: one entry is registered per LOAD cycle with >= 12 buffered bits; wr/tos appear the cycle after.
// Backpressure: din_ready drops while the 32-bit accumulator cannot take another word or all words are in.
// Optional feature: define E1B_LOADER_CKSUM_EN to add the cksum port (XOR of all written entries).
module e1b_code_loader #(
  parameter int CODELEN = 4092
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        wr,
  output logic [11:0] tos,
  output logic        busy,
  output logic        done,
`ifdef E1B_LOADER_CKSUM_EN
  output logic [11:0] cksum,
`endif
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Index of the final entry, and the number of host words that carry a full load.
  localparam logic [12:0] LAST_ENTRY = 13'(CODELEN - 1);
  localparam logic [12:0] NUM_WORDS  = 13'((CODELEN * 12 + 15) / 16);

  logic [1:0]  state;
  logic [12:0] cnt;
  logic [12:0] wcnt;
  logic [31:0] acc;
  logic [5:0]  bitcnt;
  logic        err_q;

  logic        emit;
  logic        last;
  logic        accept;
  logic [5:0]  bc_sh;
  logic [31:0] acc_sh;
  logic [31:0] acc_nx;
  logic [5:0]  bc_nx;

  // Unpack datapath: pop one entry if available, then append an accepted word above the remaining bits.
  always_comb begin
    emit   = (state == S_LOAD) && (bitcnt >= 6'd12) && (cnt <= LAST_ENTRY);
    last   = emit && (cnt == LAST_ENTRY);
    bc_sh  = emit ? (bitcnt - 6'd12) : bitcnt;
    acc_sh = emit ? (acc >> 12) : acc;
    // No word is taken in a restart or reset cycle, nor once every word of the load is in,
    // so the host never loses a word to a discard.
    din_ready = (state == S_LOAD) && !start && !rst && (bc_sh <= 6'd16) && (wcnt < NUM_WORDS);
    accept    = din_valid && din_ready;
    acc_nx    = accept ? (acc_sh | ({16'h0000, din} << bc_sh)) : acc_sh;
    bc_nx     = accept ? (bc_sh + 6'd16) : bc_sh;
  end

  assign busy = (state == S_LOAD);
  assign done = (state == S_DONE);
  assign err  = err_q;

  // Control FSM, counters, accumulator and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wcnt   <= '0;
      acc    <= '0;
      bitcnt <= '0;
      wr     <= 1'b0;
      tos    <= '0;
      err_q  <= 1'b0;
    end else if (start) begin
      // A start inside LOAD aborts: anything in flight is dropped and flagged.
      state  <= S_LOAD;
      cnt    <= '0;
      wcnt   <= '0;
      acc    <= '0;
      bitcnt <= '0;
      wr     <= 1'b0;
      err_q  <= (state == S_LOAD);
    end else begin
      wr <= 1'b0;
      if (state == S_LOAD) begin
        wr <= emit;
        if (emit) begin
          tos <= acc[11:0];
          cnt <= cnt + 13'd1;
        end
        if (accept) begin
          wcnt <= wcnt + 13'd1;
        end
        if (last) begin
          // Final entry is written on the first DONE cycle; leftover bits are thrown away.
          state  <= S_DONE;
          acc    <= '0;
          bitcnt <= '0;
        end else begin
          acc    <= acc_nx;
          bitcnt <= bc_nx;
        end
      end
    end
  end

`ifdef E1B_LOADER_CKSUM_EN
  // Running XOR of written entries; updates together with the matching wr pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum <= '0;
    end else if (start) begin
      cksum <= '0;
    end else if (emit) begin
      cksum <= cksum ^ acc[11:0];
    end
  end
`endif

endmodule

// File: tb/tb_e1b_code_loader.sv
// Directed bench for e1b_code_loader with an 8-entry load.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 unit after the rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_e1b_code_loader;

  localparam int CL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        wr;
  logic [11:0] tos;
  logic        busy;
  logic        done;
  logic        err;
`ifdef E1B_LOADER_CKSUM_EN
  logic [11:0] cksum;
`endif

  e1b_code_loader #(.CODELEN(CL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .wr        (wr),
    .tos       (tos),
    .busy      (busy),
    .done      (done),
`ifdef E1B_LOADER_CKSUM_EN
    .cksum     (cksum),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] got[$];
  logic [15:0] words[6];
  logic [11:0] exp_a[8] = '{12'h321, 12'h654, 12'h987, 12'hCBA, 12'hFED, 12'h210, 12'h543, 12'h876};
  logic [11:0] exp_c[8] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008};

  // Capture every write pulse just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (wr === 1'b1) got.push_back(tos);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pack 8 entries LSB-first into the 6 host words.
  task automatic pack(input logic [11:0] e[8]);
    logic [95:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[12*i +: 12] = e[i];
    for (int i = 0; i < 6; i++) words[i] = b[16*i +: 16];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer the words; stop early once stop_after entries were written, optionally aborting right there.
  task automatic send(input bit toggle, input int stop_after, input bit abort, output int n);
    int cyc;
    bit acc_w;
    n   = 0;
    cyc = 0;
    while (n < 6 && cyc < 200) begin
      @(negedge clk);
      if (got.size() >= stop_after) begin
        din_valid = 1'b0;
        if (abort) start = 1'b1;
        return;
      end
      din       = words[n];
      din_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      cyc++;
      #1;
      acc_w = din_valid && din_ready;
      @(posedge clk);
      if (acc_w) n++;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 100;
    while (done !== 1'b1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("done_reached", {31'b0, done}, 32'd1);
  endtask

  task automatic chk_entries(input string tag, input logic [11:0] e[8]);
    chk({tag, "_count"}, got.size(), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("%s_tos%0d", tag, i), {20'b0, got[i]}, {20'b0, e[i]});
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", {31'b0, wr}, 0);
    chk("rst_tos", {20'b0, tos}, 0);
    chk("rst_ready", {31'b0, din_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst = 1'b0;

    // Full load with din_valid held high.
    pack(exp_a);
    got.delete();
    pulse_start();
    chk("held_busy", {31'b0, busy}, 1);
    send(1'b0, 99, 1'b0, n);
    chk("held_words", n, 6);
    wait_done();
    @(negedge clk);
    chk_entries("held", exp_a);
    chk("held_ready_after", {31'b0, din_ready}, 0);
    chk("held_busy_after", {31'b0, busy}, 0);
    chk("held_err", {31'b0, err}, 0);

    // din_valid outside LOAD is ignored.
    din_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("done_ready", {31'b0, din_ready}, 0);
    chk("done_no_wr", got.size(), 8);
    chk("done_stays", {31'b0, done}, 1);
    chk("done_err", {31'b0, err}, 0);
    din_valid = 1'b0;

    // Same load with din_valid toggling every other cycle.
    got.delete();
    pulse_start();
    send(1'b1, 99, 1'b0, n);
    chk("tog_words", n, 6);
    wait_done();
    @(negedge clk);
    chk_entries("tog", exp_a);

    // Abort after three entries, then a full reload.
    got.delete();
    pulse_start();
    send(1'b0, 3, 1'b1, n);
    @(negedge clk);
    start = 1'b0;
    chk("abort_err", {31'b0, err}, 1);
    chk("abort_busy", {31'b0, busy}, 1);
    repeat (3) @(negedge clk);
    chk("abort_no_extra_wr", got.size(), 3);
    got.delete();
    send(1'b0, 99, 1'b0, n);
    wait_done();
    @(negedge clk);
    chk_entries("reload", exp_a);
    chk("reload_err_sticky", {31'b0, err}, 1);
    pulse_start();
    chk("err_cleared", {31'b0, err}, 0);

    // Reset in the middle of that load.
    got.delete();
    send(1'b0, 2, 1'b0, n);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_wr", {31'b0, wr}, 0);
    chk("mrst_tos", {20'b0, tos}, 0);
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_ready", {31'b0, din_ready}, 0);
    chk("mrst_done", {31'b0, done}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mrst_no_wr", got.size(), 2);

`ifdef E1B_LOADER_CKSUM_EN
    // Entries 1..8 XOR to 8.
    pack(exp_c);
    got.delete();
    pulse_start();
    send(1'b0, 99, 1'b0, n);
    wait_done();
    @(negedge clk);
    chk_entries("ck", exp_c);
    chk("cksum", {20'b0, cksum}, 32'h008);
    repeat (3) @(negedge clk);
    chk("cksum_stable", {20'b0, cksum}, 32'h008);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
